video_pll_ctrl: RTL

Lock/reset sequencer for the 74.25 MHz-referenced video PLL that generates the 7.093790 MHz pixel clock and its phase-shifted companion. It pulses the PLL reset, waits for and qualifies `locked`, and releases the video-domain reset only after lock is stable. It also retries a PLL that does not lock, re-sequences on loss of lock, and reports status to the core. It runs on the PLL reference clock and sits between the core reset logic and the PLL instance.

---
 rtl/video_pll_ctrl_if.sv | 23 ++
 rtl/video_pll_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/video_pll_ctrl_if.sv
// video_pll_ctrl_if: core-side and PLL-side signals of the video PLL lock/reset sequencer.
// master = the sequencer, slave = whatever drives restart/pll_locked and consumes status.
interface video_pll_ctrl_if;
  logic       restart;
  logic       pll_locked;
  logic       pll_rst;
  logic       video_rst_n;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [7:0] lost_cnt;
  logic [2:0] state;

  modport master (
    input  restart, pll_locked,
    output pll_rst, video_rst_n, ready, fail, retry_cnt, lost_cnt, state
  );

  modport slave (
    output restart, pll_locked,
    input  pll_rst, video_rst_n, ready, fail, retry_cnt, lost_cnt, state
  );
endinterface

// File: rtl/video_pll_ctrl.sv
// video_pll_ctrl: pulses the video PLL reset, qualifies lock, releases the pixel-clock
// domain reset, retries a PLL that never locks and re-sequences on loss of lock.
// Optional macro VIDEO_PLL_CTRL_LOSS_FILTER_EN: in RUN, loss is declared only after
// LOSS_FILTER consecutive unlocked cycles instead of on the first one.
//
// state     | meaning
// ----------+----------------------------------------------------------
// RESET_PLL | pll_rst high for RST_CYCLES cycles
// WAIT_LOCK | pll_rst low, waiting up to LOCK_TIMEOUT cycles for lock
// STABLE    | lock seen, must hold LOCK_STABLE consecutive cycles
// RUN       | video domain released, watching for loss of lock
// FAIL      | retries exhausted, PLL held in reset until restart
module video_pll_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 1048576,
  parameter int MAX_RETRIES  = 3,
  parameter int LOSS_FILTER  = 4
) (
  input logic              refclk,
  input logic              rst_n,
  video_pll_ctrl_if.master bus
);

  localparam int MAX_AB  = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int CNT_MAX = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] RST_LOAD = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LOAD = CW'(LOCK_STABLE - 1);
  localparam logic [1:0]    RETRY_LIM = 2'(MAX_RETRIES);

  if (RST_CYCLES < 2 || LOCK_STABLE < 1 || LOCK_TIMEOUT < 1 || LOSS_FILTER < 1) begin : g_param_check
    $error("video_pll_ctrl: RST_CYCLES must be >= 2 and the other lengths >= 1");
  end

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t        st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    retry_q, retry_nxt;
  logic [7:0]    lost_q, lost_nxt;
  logic [1:0]    sync_q;
  logic          lock_s;
  logic          loss;
  logic          pll_rst_q, ready_q, fail_q;

  assign lock_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous PLL locked flag.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], bus.pll_locked};
  end

`ifdef VIDEO_PLL_CTRL_LOSS_FILTER_EN
  localparam int            FW       = $clog2(LOSS_FILTER + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(LOSS_FILTER - 1);
  logic [FW-1:0] flt_q;

  assign loss = !lock_s && (flt_q == FLT_LAST);

  // Count consecutive unlocked cycles in RUN; a locked cycle or leaving RUN clears it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)                                            flt_q <= '0;
    else if (st != S_RUN || st_nxt != S_RUN || lock_s)     flt_q <= '0;
    else                                                   flt_q <= flt_q + 1'b1;
  end
`else
  assign loss = !lock_s;
`endif

  // Next-state, counter reload and retry/loss bookkeeping; restart overrides everything.
  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt;
    retry_nxt = retry_q;
    lost_nxt  = lost_q;
    if (bus.restart) begin
      st_nxt    = S_RESET_PLL;
      cnt_nxt   = RST_LOAD;
      retry_nxt = 2'd0;
    end else begin
      unique case (st)
        S_RESET_PLL: begin
          if (cnt == '0) begin
            st_nxt  = S_WAIT_LOCK;
            cnt_nxt = TO_LOAD;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            st_nxt  = S_STABLE;
            cnt_nxt = STB_LOAD;
          end else if (cnt == '0) begin
            if (retry_q == RETRY_LIM) begin
              st_nxt  = S_FAIL;
              cnt_nxt = '0;
            end else begin
              st_nxt    = S_RESET_PLL;
              cnt_nxt   = RST_LOAD;
              retry_nxt = retry_q + 2'd1;
            end
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            st_nxt  = S_WAIT_LOCK;
            cnt_nxt = TO_LOAD;
          end else if (cnt == '0) begin
            st_nxt    = S_RUN;
            cnt_nxt   = '0;
            retry_nxt = 2'd0;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        S_RUN: begin
          if (loss) begin
            st_nxt  = S_RESET_PLL;
            cnt_nxt = RST_LOAD;
            if (lost_q != 8'hFF) lost_nxt = lost_q + 8'd1;
          end
        end
        S_FAIL: begin
          st_nxt = S_FAIL;
        end
        default: begin
          st_nxt  = S_RESET_PLL;
          cnt_nxt = RST_LOAD;
        end
      endcase
    end
  end

  // State register; outputs are decoded from the next state so they move with it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_RESET_PLL;
      cnt       <= RST_LOAD;
      retry_q   <= 2'd0;
      lost_q    <= 8'd0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      st        <= st_nxt;
      cnt       <= cnt_nxt;
      retry_q   <= retry_nxt;
      lost_q    <= lost_nxt;
      pll_rst_q <= (st_nxt == S_RESET_PLL) || (st_nxt == S_FAIL);
      ready_q   <= (st_nxt == S_RUN);
      fail_q    <= (st_nxt == S_FAIL);
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.video_rst_n = ready_q;
  assign bus.ready       = ready_q;
  assign bus.fail        = fail_q;
  assign bus.retry_cnt   = retry_q;
  assign bus.lost_cnt    = lost_q;
  assign bus.state       = st;

endmodule
